// File: rtl/aoi_sweep_pkg.sv
// aoi_sweep_pkg: shared types and constants for the AOI truth-table sweeper.
`timescale 1ns/1ps
package aoi_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int          NUM_VECTORS = 8;
    localparam int          VEC_W       = 3;
    localparam logic [7:0]  AOI_GOLDEN  = 8'h15;

endpackage

// File: rtl/aoi_sweep_ctrl_hold_timer.sv
// hold_timer: 8-bit settle counter with synchronous clear, count enable and a
// terminal-count flag that rises on the last settle cycle of a vector.
`timescale 1ns/1ps
module hold_timer #(
    parameter int HOLD_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [7:0] count;

    // Settle counter: clear wins over enable so every vector starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 8'd0;
        end else if (clr) begin
            count <= 8'd0;
        end else if (en) begin
            count <= count + 8'd1;
        end
    end

    assign tc = (count == 8'(HOLD_CYCLES - 1));

endmodule

// File: rtl/aoi_sweep_ctrl.sv
// aoi_sweep_ctrl: drives {a,b,c} through vectors 0..7, waits HOLD_CYCLES per
// vector, captures d into result and pulses done. Optional pass/fail compare
// against EXPECTED is compiled in with `define AOI_SWEEP_CHECK_EN.
`timescale 1ns/1ps
module aoi_sweep_ctrl
    import aoi_sweep_pkg::*;
#(
    parameter int         HOLD_CYCLES = 2,
    parameter logic [7:0] EXPECTED    = AOI_GOLDEN
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    output logic                   a,
    output logic                   b,
    output logic                   c,
    input  logic                   d,
    output logic [VEC_W-1:0]       vec,
`ifdef AOI_SWEEP_CHECK_EN
    output logic                   pass,
    output logic                   fail,
`endif
    output logic                   busy,
    output logic                   done,
    output logic [NUM_VECTORS-1:0] result
);

    state_t state, state_n;
    logic   tc;
    logic   vec_clr;
    logic   vec_inc;
    logic   res_clr;
    logic   capture;
    logic   abort_acc;

    hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state != APPLY),
        .en    (state == APPLY),
        .tc    (tc)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and datapath strobes; abort beats both start and capture.
    always_comb begin
        state_n   = state;
        vec_clr   = 1'b0;
        vec_inc   = 1'b0;
        res_clr   = 1'b0;
        capture   = 1'b0;
        abort_acc = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_n = APPLY;
                    vec_clr = 1'b1;
                    res_clr = 1'b1;
                end
            end
            APPLY: begin
                if (abort) begin
                    state_n   = IDLE;
                    vec_clr   = 1'b1;
                    abort_acc = 1'b1;
                end else if (tc) begin
                    state_n = SAMPLE;
                end
            end
            SAMPLE: begin
                if (abort) begin
                    state_n   = IDLE;
                    vec_clr   = 1'b1;
                    abort_acc = 1'b1;
                end else begin
                    capture = 1'b1;
                    if (vec == VEC_W'(NUM_VECTORS - 1)) begin
                        state_n = DONE;
                    end else begin
                        state_n = APPLY;
                        vec_inc = 1'b1;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
                vec_clr = 1'b1;
            end
            default: begin
                state_n = IDLE;
                vec_clr = 1'b1;
            end
        endcase
    end

    // Vector index and truth-table capture; result survives abort and done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec    <= '0;
            result <= '0;
        end else begin
            if (vec_clr) begin
                vec <= '0;
            end else if (vec_inc) begin
                vec <= vec + VEC_W'(1);
            end
            if (res_clr) begin
                result <= '0;
            end else if (capture) begin
                result[vec] <= d;
            end
        end
    end

    // Gate inputs come straight from the vec flops, so they only move on
    // clock edges and never glitch.
    assign {a, b, c} = vec;
    assign busy      = (state == APPLY) || (state == SAMPLE);
    assign done      = (state == DONE);

`ifdef AOI_SWEEP_CHECK_EN
    // Verdict latched during DONE, cleared by a new sweep or an abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass <= 1'b0;
            fail <= 1'b0;
        end else if (res_clr || abort_acc) begin
            pass <= 1'b0;
            fail <= 1'b0;
        end else if (state == DONE) begin
            pass <= (result == EXPECTED);
            fail <= (result != EXPECTED);
        end
    end
`else
    logic unused_expected;
    logic unused_abort_acc;
    assign unused_expected  = ^EXPECTED;
    assign unused_abort_acc = abort_acc;
`endif

endmodule

// File: tb/tb_aoi_sweep_ctrl.sv
// tb_aoi_sweep_ctrl: directed bench for aoi_sweep_ctrl with an AOI gate model.
// Main DUT uses HOLD_CYCLES=2, a second instance uses HOLD_CYCLES=1.
`timescale 1ns/1ps
module tb_aoi_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort;
    logic       a, b, c, d;
    logic [2:0] vec;
    logic       busy, done;
    logic [7:0] result;
    logic       start1, abort1;
    logic       a1, b1, c1, d1;
    logic [2:0] vec1;
    logic       busy1, done1;
    logic [7:0] result1;
`ifdef AOI_SWEEP_CHECK_EN
    logic       pass, fail, pass1, fail1;
`endif

    int gate_mode;   // 0 = real AOI, 1 = stuck-at-0, 2 = stuck-at-1
    int checks   = 0;
    int failures = 0;
    int ndone, done_at;

    always #5 clk = ~clk;

    assign d  = (gate_mode == 1) ? 1'b0 :
                (gate_mode == 2) ? 1'b1 : ~((a & b) | c);
    assign d1 = ~((a1 & b1) | c1);

    aoi_sweep_ctrl #(.HOLD_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .a(a), .b(b), .c(c), .d(d), .vec(vec),
`ifdef AOI_SWEEP_CHECK_EN
        .pass(pass), .fail(fail),
`endif
        .busy(busy), .done(done), .result(result)
    );

    aoi_sweep_ctrl #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .a(a1), .b(b1), .c(c1), .d(d1), .vec(vec1),
`ifdef AOI_SWEEP_CHECK_EN
        .pass(pass1), .fail(fail1),
`endif
        .busy(busy1), .done(done1), .result(result1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one sweep on the HOLD_CYCLES=2 instance; i counts edges after the
    // edge that sampled start. restart_at pulses start before edge i.
    task automatic run_sweep(input bit chk_vec, input int restart_at,
                             output int nd, output int dat);
        start = 1'b1;
        tick();
        start = 1'b0;
        nd  = 0;
        dat = -1;
        chk("busy_after_start", busy, 1);
        chk("vec_after_start", vec, 0);
        for (int i = 1; i <= 30; i++) begin
            if (i == restart_at) start = 1'b1;
            tick();
            start = 1'b0;
            if (done) begin
                nd++;
                dat = i;
            end
            if (chk_vec && (i % 3 == 1) && (i <= 22)) begin
                chk("vec_step", vec, i / 3);
                chk("abc_step", {a, b, c}, i / 3);
                chk("busy_step", busy, 1);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        start1 = 1'b0; abort1 = 1'b0; gate_mode = 0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_vec", vec, 0);
        chk("rst_abc", {a, b, c}, 0);
        chk("rst_result", result, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Full sweep with a correct gate: done on edge 24 (cycle 25).
        run_sweep(1'b1, 0, ndone, done_at);
        chk("good_ndone", ndone, 1);
        chk("good_done_at", done_at, 24);
        chk("good_result", result, 8'h15);
        chk("good_busy_end", busy, 0);
`ifdef AOI_SWEEP_CHECK_EN
        chk("good_pass", pass, 1);
        chk("good_fail", fail, 0);
`endif

        // Stuck-at-0 gate.
        gate_mode = 1;
        run_sweep(1'b0, 0, ndone, done_at);
        gate_mode = 0;
        chk("sa0_ndone", ndone, 1);
        chk("sa0_result", result, 8'h00);
`ifdef AOI_SWEEP_CHECK_EN
        chk("sa0_pass", pass, 0);
        chk("sa0_fail", fail, 1);
`endif

        // Abort during SAMPLE of vec 3; d forced high so a leaked capture shows.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (11) tick();
        chk("abort_pre_busy", busy, 1);
        chk("abort_pre_vec", vec, 3);
        abort = 1'b1;
        gate_mode = 2;
        tick();
        abort = 1'b0;
        gate_mode = 0;
        chk("abort_busy", busy, 0);
        chk("abort_abc", {a, b, c}, 0);
        chk("abort_vec", vec, 0);
        chk("abort_result", result, 8'h05);
`ifdef AOI_SWEEP_CHECK_EN
        chk("abort_fail", fail, 0);
`endif
        ndone = done ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        chk("abort_result_hold", result, 8'h05);

        // Second start while busy at vec 5 must be ignored.
        run_sweep(1'b0, 16, ndone, done_at);
        chk("restart_ndone", ndone, 1);
        chk("restart_done_at", done_at, 24);
        chk("restart_result", result, 8'h15);

        // Asynchronous reset in the middle of APPLY, between clock edges.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("arst_pre_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_vec", vec, 0);
        chk("arst_abc", {a, b, c}, 0);
        chk("arst_result", result, 8'h00);
        chk("arst_done", done, 0);
        #2 rst_n = 1'b1;
        tick();
        run_sweep(1'b0, 0, ndone, done_at);
        chk("arst_sweep_ndone", ndone, 1);
        chk("arst_sweep_result", result, 8'h15);

        // HOLD_CYCLES=1 instance: two cycles per vector, done on edge 16.
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        ndone = 0;
        done_at = -1;
        for (int i = 1; i <= 24; i++) begin
            tick();
            if (done1) begin
                ndone++;
                done_at = i;
            end
            if (i <= 15) chk("h1_vec", vec1, i / 2);
        end
        chk("h1_ndone", ndone, 1);
        chk("h1_done_at", done_at, 16);
        chk("h1_result", result1, 8'h15);
`ifdef AOI_SWEEP_CHECK_EN
        chk("h1_pass", pass1, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
